// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI RAM master.
//   state_t    : FSM state encoding (adds ST_GAP when SPI_CS_GAP_EN is defined)
//   OP_WR/OP_RD: frame opcode bit values
//   frame_len  : bits per frame (opcode + address + data)
// Optional macro: SPI_CS_GAP_EN (adds the post-frame chip-select gap state).
package spi_pkg;

`ifdef SPI_CS_GAP_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;
`endif

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  function automatic int frame_len(input int addr_bit, input int data_bit);
    return 1 + addr_bit + data_bit;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI clock divider for mode 0.
//   CLK, RST : system clock, synchronous active-high reset
//   en       : run the divider; low holds SCLK low and reloads the counter
//   sclk     : SPI clock, starts low, toggles every CLK_DIV cycles
//   rise     : one-cycle strobe in the cycle whose closing edge raises sclk
//   fall     : one-cycle strobe in the cycle whose closing edge lowers sclk
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          tc;

  assign tc   = en && (cnt_q == '0);
  assign rise = tc && !sclk_q;
  assign fall = tc && sclk_q;
  assign sclk = sclk_q;

  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      cnt_q  <= CW'(CLK_DIV - 1);
      sclk_q <= 1'b0;
    end else if (tc) begin
      cnt_q  <= CW'(CLK_DIV - 1);
      sclk_q <= !sclk_q;
    end else begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// spi_ram_master: runs one SPI mode-0 frame per upstream command to an
// external SPI RAM. Frame, MSB first: opcode (1=write), address, data.
//   CLK, RST        : system clock, synchronous active-high reset
//   CMD             : {WR_EN, RD_EN} levels, held until the matching DONE
//   ADDR, WR_DATA   : address / write data for the pending command
//   WR_DONE/RD_DONE : one-cycle completion pulses
//   RD_DATA         : last read word (registered, valid with RD_DONE)
//   BUSY            : high from LOAD through DONE (and GAP)
//   SCLK, CS_N, MOSI, MISO : SPI bus
// Optional macro: SPI_CS_GAP_EN adds a GAP state after DONE that holds CS_N
// high for 2*CLK_DIV cycles to meet the RAM's minimum deselect time.
//
// state | meaning
// IDLE  | waiting for CMD; write wins over read
// LOAD  | CS_N low, opcode on MOSI, frame latched into shift register
// SHIFT | 2*N*CLK_DIV cycles of SCLK; sample MISO on rise, shift on fall
// DONE  | CS_N high, pulse WR_DONE or RD_DONE
// GAP   | (SPI_CS_GAP_EN only) deselect hold, CMD ignored
module spi_ram_master
  import spi_pkg::*;
#(
  parameter int DATA_BIT = 4,
  parameter int ADDR_BIT = 3,
  parameter int CLK_DIV  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          CMD,
  input  logic [ADDR_BIT-1:0] ADDR,
  input  logic [DATA_BIT-1:0] WR_DATA,
  output logic                WR_DONE,
  output logic                RD_DONE,
  output logic [DATA_BIT-1:0] RD_DATA,
  output logic                BUSY,
  output logic                SCLK,
  output logic                CS_N,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int N   = frame_len(ADDR_BIT, DATA_BIT);
  localparam int BCW = $clog2(N);

  state_t              state_q, state_d;
  logic                op_q;
  logic [N-1:0]        sr_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic [DATA_BIT-1:0] cap_q;
  logic [DATA_BIT-1:0] rd_data_q;
  logic                sclk_rise, sclk_fall;
  logic                last_fall;

`ifdef SPI_CS_GAP_EN
  localparam int GCW = $clog2(2 * CLK_DIV);
  logic [GCW-1:0] gap_cnt_q;
`endif

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .CLK  (CLK),
    .RST  (RST),
    .en   (state_q == ST_SHIFT),
    .sclk (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  assign last_fall = sclk_fall && (bit_cnt_q == '0);
  assign RD_DATA   = rd_data_q;

  always_comb begin
    state_d = state_q;
    CS_N    = 1'b1;
    BUSY    = 1'b1;
    MOSI    = 1'b0;
    WR_DONE = 1'b0;
    RD_DONE = 1'b0;
    case (state_q)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (CMD != 2'b00) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        CS_N    = 1'b0;
        MOSI    = op_q;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        CS_N = 1'b0;
        MOSI = sr_q[N-1];
        if (last_fall) state_d = ST_DONE;
      end
      ST_DONE: begin
        WR_DONE = (op_q == OP_WR);
        RD_DONE = (op_q == OP_RD);
`ifdef SPI_CS_GAP_EN
        state_d = ST_GAP;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef SPI_CS_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_RD;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      cap_q     <= '0;
      rd_data_q <= '0;
`ifdef SPI_CS_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        // Op type is decided on the IDLE->LOAD edge so MOSI can present
        // the opcode bit during LOAD itself.
        ST_IDLE: op_q <= CMD[1] ? OP_WR : OP_RD;
        ST_LOAD: begin
          sr_q      <= {op_q, ADDR, (op_q == OP_WR) ? WR_DATA : '0};
          bit_cnt_q <= BCW'(N - 1);
        end
        ST_SHIFT: begin
          // Every sample goes through; only the last DATA_BIT survive.
          if (sclk_rise) cap_q <= DATA_BIT'({cap_q, MISO});
          if (sclk_fall) begin
            sr_q <= sr_q << 1;
            if (bit_cnt_q == '0) begin
              if (op_q == OP_RD) rd_data_q <= cap_q;
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end
          end
        end
`ifdef SPI_CS_GAP_EN
        ST_DONE: gap_cnt_q <= GCW'(2 * CLK_DIV - 1);
        ST_GAP:  gap_cnt_q <= gap_cnt_q - 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with default parameters and a small
// SPI RAM model that drives MISO during the data phase of each frame.
module tb_spi_ram_master;

  localparam int DATA_BIT = 4;
  localparam int ADDR_BIT = 3;
  localparam int CLK_DIV  = 4;

`ifdef SPI_CS_GAP_EN
  localparam logic GAP_EN = 1'b1;
`else
  localparam logic GAP_EN = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [1:0]          CMD = 2'b00;
  logic [ADDR_BIT-1:0] ADDR = '0;
  logic [DATA_BIT-1:0] WR_DATA = '0;
  logic                WR_DONE, RD_DONE, BUSY, SCLK, CS_N, MOSI;
  logic [DATA_BIT-1:0] RD_DATA;
  logic                MISO;

  spi_ram_master #(
    .DATA_BIT (DATA_BIT),
    .ADDR_BIT (ADDR_BIT),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CMD     (CMD),
    .ADDR    (ADDR),
    .WR_DATA (WR_DATA),
    .WR_DONE (WR_DONE),
    .RD_DONE (RD_DONE),
    .RD_DATA (RD_DATA),
    .BUSY    (BUSY),
    .SCLK    (SCLK),
    .CS_N    (CS_N),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: counts SCLK rises in the frame, logs MOSI on each rise and
  // presents the data word MSB first for rises 4..7 (data phase).
  logic [3:0] ram_word = 4'h0;
  logic [7:0] mosi_bits = 8'h00;
  int         rises = 0;

  always @(negedge CS_N) begin
    rises     = 0;
    mosi_bits = 8'h00;
  end

  always @(posedge SCLK) begin
    if (CS_N === 1'b0) begin
      mosi_bits = {mosi_bits[6:0], MOSI};
      rises     = rises + 1;
    end
  end

  always_comb begin
    MISO = 1'b0;
    if (rises >= 4 && rises < 8) MISO = ram_word[2'(7 - rises)];
  end

  // Bus monitors, sampled on the closing edge of each cycle.
  int low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;

  always @(posedge CLK) begin
    if (WR_DONE === 1'b1 && RD_DONE === 1'b1) both_cnt <= both_cnt + 1;
    if (WR_DONE === 1'b1) wr_cnt <= wr_cnt + 1;
    if (RD_DONE === 1'b1) rd_cnt <= rd_cnt + 1;
    if (CS_N === 1'b0) begin
      low_run <= low_run + 1;
      if (high_run > 0) begin
        last_high <= high_run;
        high_run  <= 0;
      end
    end else begin
      high_run <= high_run + 1;
      if (low_run > 0) begin
        last_low <= low_run;
        low_run  <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a DONE pulse; returns which one, its cycle and RD_DATA.
  task automatic wait_done(input string tag, output logic wr, output logic rd,
                           output int at, output logic [3:0] data);
    logic found;
    found = 1'b0;
    wr = 1'b0; rd = 1'b0; at = -1; data = 4'h0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (WR_DONE === 1'b1 || RD_DONE === 1'b1) begin
        found = 1'b1;
        wr    = WR_DONE;
        rd    = RD_DONE;
        at    = cyc;
        data  = RD_DATA;
      end
    end
    check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic       wr, rd;
  int         at, t0, w0, r0;
  logic [3:0] data;
  logic       reached;

  initial begin
    // Reset state
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("rst_cs_n", CS_N, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_wr_done", WR_DONE, 0);
    check("rst_rd_done", RD_DONE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_rd_data", RD_DATA, 0);
    RST = 1'b0;

    // Write 0xA to address 5
    @(negedge CLK);
    ADDR = 3'b101; WR_DATA = 4'hA; CMD = 2'b10;
    t0 = cyc + 1;
    @(negedge CLK);
    check("wr_load_busy", BUSY, 1);
    check("wr_load_cs_n", CS_N, 0);
    check("wr_load_mosi", MOSI, 1);
    wait_done("wr", wr, rd, at, data);
    CMD = 2'b00;
    check("wr_pulse", wr, 1);
    check("wr_no_rd", rd, 0);
    // DONE is the 66th cycle after the sampling edge: 65 edges later.
    check("wr_latency", at - t0, 65);
    check("wr_mosi", mosi_bits, 8'hDA);
    check("wr_rises", rises, 8);
    @(negedge CLK);
    check("wr_single_pulse", WR_DONE, 0);
    check("wr_cs_low_len", last_low, 65);
    check("wr_busy_after", BUSY, GAP_EN);
    @(negedge CLK);

    // Read address 3; RAM returns 0x6; WR_DATA must not reach MOSI
    ram_word = 4'h6;
    ADDR = 3'b011; WR_DATA = 4'hF; CMD = 2'b01;
    wait_done("rd", wr, rd, at, data);
    CMD = 2'b00;
    check("rd_pulse", rd, 1);
    check("rd_no_wr", wr, 0);
    check("rd_data_with_done", data, 4'h6);
    check("rd_mosi", mosi_bits, 8'h30);
    @(negedge CLK);
    check("rd_single_pulse", RD_DONE, 0);
    @(negedge CLK);

    // Simultaneous: write first, then the still-pending read
    ram_word = 4'h9;
    ADDR = 3'b010; WR_DATA = 4'h5; CMD = 2'b11;
    wait_done("sim_wr", wr, rd, at, data);
    CMD = 2'b01;
    check("sim_first_is_wr", wr, 1);
    check("sim_first_not_rd", rd, 0);
    check("sim_wr_mosi", mosi_bits, 8'hA5);
`ifdef SPI_CS_GAP_EN
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      @(negedge CLK);
      check("gap_busy", BUSY, 1);
    end
`endif
    wait_done("sim_rd", wr, rd, at, data);
    CMD = 2'b00;
    check("sim_second_is_rd", rd, 1);
    check("sim_second_not_wr", wr, 0);
    check("sim_rd_data", data, 4'h9);
    check("sim_rd_mosi", mosi_bits, 8'h20);
    @(negedge CLK);
    check("sim_never_both", both_cnt, 0);
    if (GAP_EN) check("sim_cs_gap_ge9", {31'd0, last_high >= 9}, 1);
    else        check("sim_cs_gap", last_high, 2);
    @(negedge CLK);

    // Stability: inputs change mid-frame, frame keeps latched values
    ADDR = 3'b110; WR_DATA = 4'h3; CMD = 2'b10;
    repeat (10) @(negedge CLK);
    ADDR = 3'b000; WR_DATA = 4'h0;
    wait_done("stab", wr, rd, at, data);
    CMD = 2'b00;
    check("stab_wr", wr, 1);
    check("stab_mosi", mosi_bits, 8'hE3);
    check("stab_rd_data_held", RD_DATA, 4'h9);
    repeat (2) @(negedge CLK);

    // Reset mid-frame at bit 4, then clean restart of the pending write
    ADDR = 3'b001; WR_DATA = 4'hF; CMD = 2'b10;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge CLK);
      if (rises == 4) reached = 1'b1;
    end
    check("mid_reached_bit4", {31'd0, reached}, 1);
    w0 = wr_cnt; r0 = rd_cnt;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("mid_rst_cs_n", CS_N, 1);
    check("mid_rst_sclk", SCLK, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_rd_data", RD_DATA, 0);
    check("mid_rst_no_wr_done", wr_cnt - w0, 0);
    check("mid_rst_no_rd_done", rd_cnt - r0, 0);
    RST = 1'b0;
    wait_done("restart", wr, rd, at, data);
    CMD = 2'b00;
    check("restart_wr", wr, 1);
    check("restart_mosi", mosi_bits, 8'h9F);
    check("restart_rises", rises, 8);
    @(negedge CLK);
    check("restart_one_done", wr_cnt - w0, 1);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
